// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-subset pipeline control path.
//   OP_*     : instr[31:26] opcodes
//   FUNCT_*  : instr[5:0] function codes under the SPECIAL opcode
//   MEMTOREG_*, REGDST_*, ALUOP_*, EXTOP_*, NPCOP_* : 2-bit datapath select codes
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] FUNCT_NOP   = 6'b000000;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;

  localparam logic [1:0] MEMTOREG_ALU = 2'd0;
  localparam logic [1:0] MEMTOREG_MEM = 2'd1;
  localparam logic [1:0] MEMTOREG_PC8 = 2'd2;

  localparam logic [1:0] REGDST_RT    = 2'd0;
  localparam logic [1:0] REGDST_RD    = 2'd1;
  localparam logic [1:0] REGDST_RA    = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_SUB    = 2'd1;
  localparam logic [1:0] ALUOP_OR     = 2'd2;
  localparam logic [1:0] ALUOP_LUI    = 2'd3;

  localparam logic [1:0] EXTOP_ZERO   = 2'd0;
  localparam logic [1:0] EXTOP_SIGN   = 2'd1;
  localparam logic [1:0] EXTOP_HIGH   = 2'd2;

  localparam logic [1:0] NPCOP_PC4    = 2'd0;
  localparam logic [1:0] NPCOP_BEQ    = 2'd1;
  localparam logic [1:0] NPCOP_JUMP   = 2'd2;
  localparam logic [1:0] NPCOP_REG    = 2'd3;

endpackage

// File: rtl/ctrl_decode.sv
// Main-control decoder for the MIPS-subset pipeline; one copy per stage.
// Decode is purely combinational; the only state is the sticky illegal_seen flag.
// Ports:
//   clk, reset           : clock and synchronous active-high reset (clears illegal_seen)
//   Op, Func             : instr[31:26], instr[5:0]
//   R..jal               : one-hot instruction flags (R is any SPECIAL opcode)
//   RegWrite..NPCOp      : derived datapath controls
//   illegal              : combinational, instruction is neither a listed one nor nop
//   illegal_seen         : sticky, set on any clock edge that sees illegal
module ctrl_decode
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  output logic       R,
  output logic       addu,
  output logic       subu,
  output logic       jr,
  output logic       ori,
  output logic       lw,
  output logic       sw,
  output logic       beq,
  output logic       lui,
  output logic       j,
  output logic       jal,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ExtOp,
  output logic [1:0] NPCOp,
  output logic       illegal,
  output logic       illegal_seen
);

  logic nop;

  // Instruction flags
  always_comb begin
    R    = 1'b0;
    addu = 1'b0;
    subu = 1'b0;
    jr   = 1'b0;
    ori  = 1'b0;
    lw   = 1'b0;
    sw   = 1'b0;
    beq  = 1'b0;
    lui  = 1'b0;
    j    = 1'b0;
    jal  = 1'b0;
    nop  = 1'b0;
    case (Op)
      OP_SPECIAL: begin
        R = 1'b1;
        case (Func)
          FUNCT_NOP:  nop  = 1'b1;
          FUNCT_ADDU: addu = 1'b1;
          FUNCT_SUBU: subu = 1'b1;
          FUNCT_JR:   jr   = 1'b1;
          default:    ;
        endcase
      end
      OP_ORI:  ori = 1'b1;
      OP_LW:   lw  = 1'b1;
      OP_SW:   sw  = 1'b1;
      OP_BEQ:  beq = 1'b1;
      OP_LUI:  lui = 1'b1;
      OP_J:    j   = 1'b1;
      OP_JAL:  jal = 1'b1;
      default: ;
    endcase
  end

  // Derived controls; every unlisted instruction falls through to the all-zero defaults
  always_comb begin
    RegWrite = addu | subu | ori | lw | lui | jal;
    MemWrite = sw;
    ALUSrc   = ori | lw | sw | lui;

    MemtoReg = MEMTOREG_ALU;
    if (lw)       MemtoReg = MEMTOREG_MEM;
    else if (jal) MemtoReg = MEMTOREG_PC8;

    // R-format writes rd even for nop/illegal SPECIAL; harmless since RegWrite is 0 there
    RegDst = REGDST_RT;
    if (R)        RegDst = REGDST_RD;
    else if (jal) RegDst = REGDST_RA;

    ALUOp = ALUOP_ADD;
    if (subu | beq) ALUOp = ALUOP_SUB;
    else if (ori)   ALUOp = ALUOP_OR;
    else if (lui)   ALUOp = ALUOP_LUI;

    ExtOp = EXTOP_ZERO;
    if (lw | sw | beq) ExtOp = EXTOP_SIGN;
    else if (lui)      ExtOp = EXTOP_HIGH;

    NPCOp = NPCOP_PC4;
    if (beq)          NPCOp = NPCOP_BEQ;
    else if (j | jal) NPCOp = NPCOP_JUMP;
    else if (jr)      NPCOp = NPCOP_REG;

    illegal = ~(addu | subu | jr | ori | lw | sw | beq | lui | j | jal | nop);
  end

  // Sticky illegal flag; reset wins over a simultaneous illegal
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_seen <= 1'b0;
    end else if (illegal) begin
      illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_decode.sv
module tb_ctrl_decode;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       R, addu, subu, jr, ori, lw, sw, beq, lui, j, jal;
  logic       RegWrite, MemWrite, ALUSrc, illegal, illegal_seen;
  logic [1:0] MemtoReg, RegDst, ALUOp, ExtOp, NPCOp;

  int n_cmp;
  int n_bad;

  // {R,addu,subu,jr,ori,lw,sw,beq,lui,j,jal}
  logic [10:0] flags;
  // {RegWrite,MemWrite,MemtoReg,RegDst,ALUSrc,ALUOp,ExtOp,NPCOp,illegal}
  logic [13:0] ctrl;

  assign flags = {R, addu, subu, jr, ori, lw, sw, beq, lui, j, jal};
  assign ctrl  = {RegWrite, MemWrite, MemtoReg, RegDst, ALUSrc, ALUOp, ExtOp, NPCOp, illegal};

  ctrl_decode dut (
    .clk          (clk),
    .reset        (reset),
    .Op           (Op),
    .Func         (Func),
    .R            (R),
    .addu         (addu),
    .subu         (subu),
    .jr           (jr),
    .ori          (ori),
    .lw           (lw),
    .sw           (sw),
    .beq          (beq),
    .lui          (lui),
    .j            (j),
    .jal          (jal),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .MemtoReg     (MemtoReg),
    .RegDst       (RegDst),
    .ALUSrc       (ALUSrc),
    .ALUOp        (ALUOp),
    .ExtOp        (ExtOp),
    .NPCOp        (NPCOp),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Op = 6'h00; Func = 6'h00;
    tick();
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_seen: got %b want 0", illegal_seen);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL nop_after_reset_seen: got %b want 0", illegal_seen);
    end
  endtask

  task automatic test_rtype();
    logic [10:0] ef;
    logic [13:0] ec;
    Op = 6'h00;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin Func = 6'h21; ef = 11'b11000000000;
                 ec = {1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0}; end
        1: begin Func = 6'h23; ef = 11'b10100000000;
                 ec = {1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0}; end
        default: begin Func = 6'h08; ef = 11'b10010000000;
                 ec = {1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0}; end
      endcase
      #1;
      n_cmp++;
      if (flags !== ef) begin
        n_bad++;
        $display("FAIL rtype_flags func=%h: got %b want %b", Func, flags, ef);
      end
      n_cmp++;
      if (ctrl !== ec) begin
        n_bad++;
        $display("FAIL rtype_ctrl func=%h: got %b want %b", Func, ctrl, ec);
      end
    end
  endtask

  task automatic test_itype();
    logic [10:0] ef;
    logic [13:0] ec;
    for (int i = 0; i < 7; i++) begin
      Func = 6'h21; // nonzero Func must be ignored for non-SPECIAL opcodes
      case (i)
        0: begin Op = 6'h23; ef = 11'b00000100000; // lw
                 ec = {1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b0}; end
        1: begin Op = 6'h2b; ef = 11'b00000010000; // sw
                 ec = {1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b0}; end
        2: begin Op = 6'h04; ef = 11'b00000001000; // beq
                 ec = {1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd1, 2'd1, 1'b0}; end
        3: begin Op = 6'h0f; ef = 11'b00000000100; // lui
                 ec = {1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 2'd2, 2'd0, 1'b0}; end
        4: begin Op = 6'h0d; ef = 11'b00001000000; // ori
                 ec = {1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0}; end
        5: begin Op = 6'h02; ef = 11'b00000000010; // j
                 ec = {1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0}; end
        default: begin Op = 6'h03; ef = 11'b00000000001; // jal
                 ec = {1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0}; end
      endcase
      #1;
      n_cmp++;
      if (flags !== ef) begin
        n_bad++;
        $display("FAIL itype_flags op=%h: got %b want %b", Op, flags, ef);
      end
      n_cmp++;
      if (ctrl !== ec) begin
        n_bad++;
        $display("FAIL itype_ctrl op=%h: got %b want %b", Op, ctrl, ec);
      end
    end
    // Legal traffic alone must never set the sticky flag
    tick();
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL legal_seen: got %b want 0", illegal_seen);
    end
  endtask

  task automatic test_nop_illegal();
    logic [10:0] ef;
    logic [13:0] ec;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin Op = 6'h00; Func = 6'h00; ef = 11'b10000000000; // nop
                 ec = {1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0}; end
        1: begin Op = 6'h00; Func = 6'h3f; ef = 11'b10000000000; // bad funct
                 ec = {1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1}; end
        default: begin Op = 6'h3f; Func = 6'h00; ef = 11'b00000000000; // bad op
                 ec = {1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1}; end
      endcase
      #1;
      n_cmp++;
      if (flags !== ef) begin
        n_bad++;
        $display("FAIL nopill_flags op=%h func=%h: got %b want %b", Op, Func, flags, ef);
      end
      n_cmp++;
      if (ctrl !== ec) begin
        n_bad++;
        $display("FAIL nopill_ctrl op=%h func=%h: got %b want %b", Op, Func, ctrl, ec);
      end
    end
    tick();
    n_cmp++;
    if (illegal_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL seen_set: got %b want 1", illegal_seen);
    end
    Op = 6'h00; Func = 6'h00;
    tick();
    n_cmp++;
    if (illegal_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL seen_sticky: got %b want 1", illegal_seen);
    end
  endtask

  task automatic test_sticky_reset();
    Op = 6'h3f; Func = 6'h00;
    reset = 1'b1;
    tick();
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_dominates: got %b want 0", illegal_seen);
    end
    n_cmp++;
    if (illegal !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_under_reset: got %b want 1", illegal);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (illegal_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL seen_after_reset: got %b want 1", illegal_seen);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    Op    = 6'h00;
    Func  = 6'h00;
    test_reset();
    test_rtype();
    test_itype();
    test_nop_illegal();
    test_sticky_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
